debug_strobe_ctrl: RTL

DEBUG_STROBE_CTRL -- requirements
Module: debug_strobe_ctrl

---
 rtl/debug_strobe_pkg.sv | 14 +
 rtl/debug_strobe_ctrl_if.sv | 27 ++
 rtl/strobe_timer.sv | 32 +++
 rtl/debug_strobe_ctrl.sv | 102 ++++++++++
 4 files changed

// File: rtl/debug_strobe_pkg.sv
// Shared state encoding and default widths for the debug strobe controller.
// Pure declarations: no timing or flow-control behaviour lives here.
package debug_strobe_pkg;

    localparam int PERIOD_W_DEF = 16;
    localparam int COUNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/debug_strobe_ctrl_if.sv
// Control and status bundle between a strobe requester and debug_strobe_ctrl.
// Requests are level-sampled each edge; status outputs are registered.
interface debug_strobe_ctrl_if
    import debug_strobe_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int COUNT_W  = COUNT_W_DEF
);
    logic                start;
    logic                stop;
    logic [PERIOD_W-1:0] period;
    logic [COUNT_W-1:0]  count;
    logic                en_out;
    logic                busy;
    logic                done;
    logic [COUNT_W-1:0]  pulse_cnt;

    modport master (
        output start, stop, period, count,
        input  en_out, busy, done, pulse_cnt
    );

    modport slave (
        input  start, stop, period, count,
        output en_out, busy, done, pulse_cnt
    );
endinterface

// File: rtl/strobe_timer.sv
// Reloading period down-counter; expire marks the cycle before each strobe edge.
// load wins over run; expire is qualified by run, so it never fires while parked.
module strobe_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    output logic         expire
);

    logic [W-1:0] per_q;
    logic [W-1:0] cnt_q;

    // Loading val-1 makes expire land in the cycle ending at edge k+val.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            per_q <= load_val;
            cnt_q <= load_val - W'(1);
        end else if (run) begin
            cnt_q <= (cnt_q == '0) ? (per_q - W'(1)) : (cnt_q - W'(1));
        end
    end

    assign expire = run && (cnt_q == '0);

endmodule

// File: rtl/debug_strobe_ctrl.sv
// Issues N one-cycle en_out strobes every P cycles after start (N=0: until stop).
// First strobe follows the accepting edge by P edges; all outputs are registered.
module debug_strobe_ctrl
    import debug_strobe_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int COUNT_W  = COUNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    debug_strobe_ctrl_if.slave  bus
);

    state_t               state;
    logic [COUNT_W-1:0]   n_q;
    logic [COUNT_W-1:0]   pcnt_q;
    logic                 fin_q;
    logic                 en_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 accept;
    logic                 run;
    logic                 expire;
    logic [PERIOD_W-1:0]  p_eff;

    assign accept = (state == IDLE) && bus.start && !bus.stop;
    assign run    = (state == RUN);
    assign p_eff  = (bus.period == '0) ? PERIOD_W'(1) : bus.period;

    strobe_timer #(.W(PERIOD_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (p_eff),
        .run      (run),
        .expire   (expire)
    );

    // fin_q marks that strobe N was just issued; the following edge moves to DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            n_q    <= '0;
            pcnt_q <= '0;
            fin_q  <= 1'b0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    en_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (accept) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        n_q    <= bus.count;
                        pcnt_q <= '0;
                        fin_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        en_q   <= 1'b0;
                        fin_q  <= 1'b0;
                    end else if (fin_q) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        en_q   <= 1'b0;
                        done_q <= 1'b1;
                        fin_q  <= 1'b0;
                    end else if (expire) begin
                        en_q   <= 1'b1;
                        pcnt_q <= pcnt_q + COUNT_W'(1);
                        fin_q  <= (n_q != '0) && ((pcnt_q + COUNT_W'(1)) == n_q);
                    end else begin
                        en_q   <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    en_q   <= 1'b0;
                    done_q <= 1'b0;
                    fin_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.en_out    = en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pulse_cnt = pcnt_q;

endmodule
